// File: rtl/l1c_axi_master.sv
// L1 cache to AXI4 master bridge: 4-word line fills and single-beat strobed writes.
// Define L1C_AXI_BURST_EN for one ARLEN=3 burst per fill; otherwise four single-beat reads.
module l1c_axi_master #(
  parameter logic [3:0] MASTER_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic        c_write,
  input  logic [31:0] c_in,
  input  logic [2:0]  c_type,
  output logic [31:0] c_out,
  output logic        c_wait,
  output logic        bus_err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam logic [2:0] CACHE_BYTE    = 3'd0;
  localparam logic [2:0] CACHE_HWORD   = 3'd1;
  localparam logic [2:0] CACHE_BYTE_U  = 3'd3;
  localparam logic [2:0] CACHE_HWORD_U = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WRESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_beat;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_c_out;
  logic        r_c_wait;
  logic        r_bus_err;
  logic        w_accept;
  logic        w_r_hs;
  logic        w_b_hs;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic        w_unused;

  // Block acceptance during an ack cycle so a still-held c_req is not re-taken.
  assign w_accept = (r_state == S_IDLE) && c_req && r_c_wait;
  assign w_r_hs   = RVALID && RREADY;
  assign w_b_hs   = BVALID && BREADY;
  assign w_unused = ^{RID, BID, RLAST};

  always_comb begin
    w_strb = 4'hF;
    case (c_type)
      CACHE_BYTE, CACHE_BYTE_U:   w_strb = 4'b0001 << c_addr[1:0];
      CACHE_HWORD, CACHE_HWORD_U: w_strb = 4'b0011 << {c_addr[1], 1'b0};
      default:                    w_strb = 4'hF;
    endcase
  end

  assign w_wdata = c_in << {c_addr[1:0], 3'b000};

  always_comb begin
    w_next  = r_state;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = c_write ? S_WADDR : S_RADDR;
      end
      S_RADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_next = S_RDATA;
      end
      S_RDATA: begin
        RREADY = 1'b1;
        if (RVALID) begin
          if (r_beat == 3'd3) w_next = S_IDLE;
`ifndef L1C_AXI_BURST_EN
          else w_next = S_RADDR;
`endif
        end
      end
      S_WADDR: begin
        AWVALID = !r_aw_done;
        WVALID  = !r_w_done;
        if ((r_aw_done || AWREADY) && (r_w_done || WREADY)) w_next = S_WRESP;
      end
      S_WRESP: begin
        BREADY = 1'b1;
        if (BVALID) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_beat    <= 3'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_c_out   <= 32'h0;
      r_c_wait  <= 1'b1;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_c_wait  <= 1'b1;
      r_bus_err <= 1'b0;
      if (w_accept) begin
        r_addr    <= c_addr;
        r_wdata   <= w_wdata;
        r_wstrb   <= w_strb;
        r_beat    <= 3'd0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_r_hs) begin
        r_c_out   <= RDATA;
        r_beat    <= r_beat + 3'd1;
        r_c_wait  <= 1'b0;
        r_bus_err <= (RRESP != 2'b00);
      end
      if (AWVALID && AWREADY) r_aw_done <= 1'b1;
      if (WVALID && WREADY) r_w_done <= 1'b1;
      if (w_b_hs) begin
        r_c_wait  <= 1'b0;
        r_bus_err <= (BRESP != 2'b00);
      end
    end
  end

`ifdef L1C_AXI_BURST_EN
  assign ARADDR = {r_addr[31:4], 4'h0};
  assign ARLEN  = 4'd3;
`else
  assign ARADDR = {r_addr[31:4], r_beat[1:0], 2'b00};
  assign ARLEN  = 4'd0;
`endif

  assign ARID    = MASTER_ID;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWID    = MASTER_ID;
  assign AWADDR  = r_addr;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign WDATA   = r_wdata;
  assign WSTRB   = r_wstrb;
  assign WLAST   = 1'b1;
  assign c_out   = r_c_out;
  assign c_wait  = r_c_wait;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_l1c_axi_master.sv
// Self-checking bench for l1c_axi_master: AXI slave model plus line/write expectation queues.
module tb_l1c_axi_master;

  localparam logic [3:0] MID = 4'h5;
  localparam logic [2:0] T_BYTE = 3'd0, T_HWORD = 3'd1, T_WORD = 3'd2, T_BYTE_U = 3'd3, T_HWORD_U = 3'd4;
`ifdef L1C_AXI_BURST_EN
  localparam int AR_PER_LINE = 1;
`else
  localparam int AR_PER_LINE = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_req = 1'b0, c_write = 1'b0;
  logic [31:0] c_addr = 32'h0, c_in = 32'h0;
  logic [2:0] c_type = 3'd0;
  logic [31:0] c_out;
  logic c_wait, bus_err;
  logic [3:0] ARID, ARLEN, AWID, AWLEN, WSTRB;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [2:0] ARSIZE, AWSIZE;
  logic [1:0] ARBURST, AWBURST;
  logic ARVALID, RREADY, AWVALID, WLAST, WVALID, BREADY;
  logic ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [3:0] RID = 4'h0, BID = 4'h0;
  logic [31:0] RDATA = 32'h0;
  logic [1:0] RRESP = 2'b00, BRESP = 2'b00;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_ar_addr[$];
  logic [3:0]  exp_ar_len[$];
  logic [31:0] exp_aw_addr[$];
  logic [31:0] exp_w_data[$];
  logic [3:0]  exp_w_strb[$];
  logic [31:0] exp_ack_data[$];
  logic        exp_ack_err[$];
  logic [31:0] model_c_out = 32'h0;

  logic [31:0] rd_seed = 32'h0;
  int err_beat = -1;
  int ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [1:0] b_resp = 2'b00;

  logic [31:0] ar_log[$];
  int aw_count = 0, err_pulses = 0, ack_run = 0, max_run = 0, first_ack = -1;
  logic [31:0] last_c_out = 32'h0, last_awaddr = 32'h0, last_wdata = 32'h0;
  logic [3:0] last_wstrb = 4'h0;

  l1c_axi_master #(.MASTER_ID(MID)) dut (
    .clk(clk), .rst(rst), .c_req(c_req), .c_addr(c_addr), .c_write(c_write), .c_in(c_in),
    .c_type(c_type), .c_out(c_out), .c_wait(c_wait), .bus_err(bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] strb_of(input logic [2:0] typ, input logic [31:0] a);
    int n, off;
    logic [3:0] s;
    n = (typ == T_BYTE || typ == T_BYTE_U) ? 1 : (typ == T_HWORD || typ == T_HWORD_U) ? 2 : 4;
    off = (int'(a[1:0]) / n) * n;
    s = 4'h0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  // Cache-side compare: every ack cycle must match the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (!c_wait) begin
        last_c_out = c_out;
        ack_run++;
        if (ack_run > max_run) max_run = ack_run;
        if (bus_err) err_pulses++;
        if (exp_ack_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack c_out=0x%08h required=no_ack", c_out);
        end else begin
          chk("ack_c_out", c_out, exp_ack_data.pop_front());
          chk("ack_bus_err", {31'b0, bus_err}, {31'b0, exp_ack_err.pop_front()});
        end
      end else begin
        ack_run = 0;
        chk("bus_err_idle", {31'b0, bus_err}, 32'h0);
      end
    end
  end

  // AXI slave: drives at negedge; a handshake is valid&ready as seen here.
  initial begin : slave
    logic [31:0] r_q[$];
    logic        r_last_q[$];
    int ar_wait, aw_wait, w_wait;
    bit aw_got, w_got, b_pend;
    ar_wait = 0; aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_q.delete(); r_last_q.delete();
        ar_wait = 0; aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ARREADY = 0; RVALID = 0; RLAST = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
      end else begin
        if (r_q.size() > 0) begin
          RVALID = 1'b1;
          RDATA  = rd_seed + {30'b0, r_q[0][3:2]};
          RRESP  = (int'(r_q[0][3:2]) == err_beat) ? 2'b10 : 2'b00;
          RLAST  = r_last_q[0];
          if (RREADY) begin
            void'(r_q.pop_front());
            void'(r_last_q.pop_front());
          end
        end else begin
          RVALID = 1'b0;
          RLAST  = 1'b0;
        end
        if (ARVALID) begin
          ARREADY = (ar_wait >= ar_delay);
          if (ARREADY) ar_wait = 0; else ar_wait++;
        end else ARREADY = 1'b0;
        if (ARVALID && ARREADY) begin
          ar_log.push_back(ARADDR);
          if (exp_ar_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ar araddr=0x%08h required=none", ARADDR);
          end else begin
            chk("araddr", ARADDR, exp_ar_addr.pop_front());
            chk("arlen", {28'b0, ARLEN}, {28'b0, exp_ar_len.pop_front()});
          end
          chk("ar_attr", {ARID, 3'b0, ARSIZE, 2'b0, ARBURST}, {MID, 3'b0, 3'b010, 2'b0, 2'b01});
          for (int i = 0; i <= int'(ARLEN); i++) begin
            r_q.push_back(ARADDR + 32'(4 * i));
            r_last_q.push_back(i == int'(ARLEN));
          end
        end
        if (b_pend) begin
          BVALID = 1'b1;
          BRESP  = b_resp;
          if (BREADY) b_pend = 0;
        end else BVALID = 1'b0;
        if (AWVALID) begin
          AWREADY = (aw_wait >= aw_delay);
          if (AWREADY) aw_wait = 0; else aw_wait++;
        end else AWREADY = 1'b0;
        if (WVALID) begin
          WREADY = (w_wait >= w_delay);
          if (WREADY) w_wait = 0; else w_wait++;
        end else WREADY = 1'b0;
        if (AWVALID && AWREADY) begin
          aw_count++;
          aw_got = 1;
          last_awaddr = AWADDR;
          if (exp_aw_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_aw awaddr=0x%08h required=none", AWADDR);
          end else chk("awaddr", AWADDR, exp_aw_addr.pop_front());
          chk("aw_attr", {AWID, AWLEN, 2'b0, AWBURST}, {MID, 4'd0, 2'b0, 2'b01});
        end
        if (WVALID && WREADY) begin
          w_got = 1;
          last_wdata = WDATA;
          last_wstrb = WSTRB;
          if (exp_w_data.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_w wdata=0x%08h required=none", WDATA);
          end else begin
            chk("wdata", WDATA, exp_w_data.pop_front());
            chk("wstrb", {28'b0, WSTRB}, {28'b0, exp_w_strb.pop_front()});
          end
          chk("wlast", {31'b0, WLAST}, 32'h1);
        end
        if (aw_got && w_got) begin
          b_pend = 1;
          aw_got = 0;
          w_got = 0;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] din,
                        input logic [2:0] typ, input int abort_after);
    int n, acks, cyc;
    logic [31:0] base;
    n = wr ? 1 : 4;
    if (wr) begin
      exp_aw_addr.push_back(addr);
      exp_w_data.push_back(din << (8 * addr[1:0]));
      exp_w_strb.push_back(strb_of(typ, addr));
      exp_ack_data.push_back(model_c_out);
      exp_ack_err.push_back(b_resp != 2'b00);
    end else begin
      base = addr & ~32'hF;
`ifdef L1C_AXI_BURST_EN
      exp_ar_addr.push_back(base);
      exp_ar_len.push_back(4'd3);
`else
      for (int i = 0; i < 4; i++) begin
        exp_ar_addr.push_back(base + 32'(4 * i));
        exp_ar_len.push_back(4'd0);
      end
`endif
      for (int i = 0; i < 4; i++) begin
        exp_ack_data.push_back(rd_seed + 32'(i));
        exp_ack_err.push_back(i == err_beat);
      end
      model_c_out = rd_seed + 32'd3;
    end
    c_write = wr; c_addr = addr; c_in = din; c_type = typ; c_req = 1'b1;
    acks = 0; cyc = 0; first_ack = -1;
    while (acks < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!c_wait) begin
        acks++;
        if (first_ack < 0) first_ack = cyc;
      end
      if (abort_after > 0 && acks >= abort_after) break;
    end
    c_req = 1'b0;
    if (acks < n && !(abort_after > 0 && acks >= abort_after)) begin
      checks++;
      failures++;
      $display("FAIL req_timeout addr=0x%08h acks=%0d required=%0d", addr, acks, n);
    end
  endtask

  task automatic post_check();
    repeat (2) @(negedge clk);
    chk("acks_pending", exp_ack_data.size(), 32'h0);
    chk("ars_pending", exp_ar_addr.size(), 32'h0);
    chk("writes_pending", exp_aw_addr.size() + exp_w_data.size(), 32'h0);
  endtask

  initial begin
    int aw0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {25'b0, ARVALID, RREADY, AWVALID, WVALID, BREADY, c_wait, bus_err}, 32'h2);
    chk("reset_c_out", c_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    rd_seed = 32'hA0; max_run = 0; ar_log.delete();
    do_req(1'b0, 32'h0000_1234, 32'h0, T_WORD, 0);
    chk("t1_first_ack_cycle", first_ack, 32'd3);
    post_check();
    chk("t1_ar_count", ar_log.size(), AR_PER_LINE);
    chk("t1_araddr0", ar_log.size() > 0 ? ar_log[0] : 32'hFFFF_FFFF, 32'h1230);
    chk("t1_last_c_out", last_c_out, 32'hA3);
`ifdef L1C_AXI_BURST_EN
    chk("t1_ack_run", max_run, 32'd4);
`else
    chk("t1_ack_run", max_run, 32'd1);
`endif

    err_pulses = 0;
    do_req(1'b1, 32'h103, 32'h5A, T_BYTE, 0);
    chk("t2_first_ack_cycle", first_ack, 32'd3);
    post_check();
    chk("t2_awaddr", last_awaddr, 32'h103);
    chk("t2_wstrb", {28'b0, last_wstrb}, 32'h8);
    chk("t2_wdata", last_wdata, 32'h5A00_0000);
    chk("t2_c_out_held", last_c_out, 32'hA3);

    aw_delay = 0; w_delay = 3; aw0 = aw_count;
    do_req(1'b1, 32'h2000, 32'hDEAD_BEEF, T_WORD, 0);
    chk("t3_first_ack_cycle", first_ack, 32'd6);
    post_check();
    chk("t3_aw_count", aw_count - aw0, 32'd1);
    chk("t3_wstrb", {28'b0, last_wstrb}, 32'hF);

    aw_delay = 2; w_delay = 0;
    do_req(1'b1, 32'h206, 32'h1234, T_HWORD_U, 0);
    post_check();
    chk("t4_wstrb", {28'b0, last_wstrb}, 32'hC);
    chk("t4_wdata", last_wdata, 32'h1234_0000);
    aw_delay = 0;

    rd_seed = 32'h100; err_beat = 1; ar_delay = 1; err_pulses = 0;
    do_req(1'b0, 32'h4008, 32'h0, T_WORD, 0);
    post_check();
    chk("t5_err_pulses", err_pulses, 32'd1);
    chk("t5_last_c_out", last_c_out, 32'h103);
    err_beat = -1; ar_delay = 0;

    b_resp = 2'b10; err_pulses = 0;
    do_req(1'b1, 32'h300, 32'h0BAD_F00D, T_WORD, 0);
    post_check();
    chk("t6_err_pulses", err_pulses, 32'd1);
    b_resp = 2'b00;

    rd_seed = 32'h300;
    do_req(1'b0, 32'h8008, 32'h0, T_WORD, 2);
    #2 rst = 1'b1;
    exp_ack_data.delete(); exp_ack_err.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
    model_c_out = 32'h0;
    #1;
    chk("t7_rst_flags", {26'b0, ARVALID, RREADY, AWVALID, WVALID, BREADY, c_wait}, 32'h1);
    chk("t7_rst_c_out", c_out, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    ar_log.delete(); rd_seed = 32'h400;
    @(negedge clk);
    do_req(1'b0, 32'h8008, 32'h0, T_WORD, 0);
    post_check();
    chk("t7_ar_count", ar_log.size(), AR_PER_LINE);
    chk("t7_araddr0", ar_log.size() > 0 ? ar_log[0] : 32'hFFFF_FFFF, 32'h8000);
    chk("t7_last_c_out", last_c_out, 32'h403);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_reached required=finish");
    $fatal(1);
  end

endmodule
